// File: rtl/npc_redirect_unit_pkg.sv
// npc_redirect_unit_pkg
//   Definitions shared by the IF-stage next-PC unit, the ID decoder and the
//   hazard unit: 3-bit next-PC kind encodings and the default fetch window.
//   Contents:
//     NPC_NONE/NPC_BR/NPC_J/NPC_JR/NPC_BRL  id_kind encodings
//     NPC_RESET_PC     fetch address loaded on reset
//     NPC_IMEM_LIMIT   highest legal instruction address (inclusive)
package npc_redirect_unit_pkg;

    localparam logic [2:0] NPC_NONE = 3'd0;
    localparam logic [2:0] NPC_BR   = 3'd1;  // conditional branch
    localparam logic [2:0] NPC_J    = 3'd2;  // J / JAL, region jump
    localparam logic [2:0] NPC_JR   = 3'd3;  // JR / JALR, register target
    localparam logic [2:0] NPC_BRL  = 3'd4;  // branch-likely

    localparam logic [31:0] NPC_RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] NPC_IMEM_LIMIT = 32'h0000_6FFF;

    // Sign-extended, word-scaled branch offset.
    function automatic logic [31:0] npc_br_offset(input logic [15:0] imm16);
        return {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/npc_redirect_unit_target_calc.sv
// npc_target_calc
//   Pure combinational redirect target mux for the ID-resolved control
//   transfer, plus the link address. Branch-likely resolves exactly like a
//   plain branch here; only its not-taken squash lives in the top level.
//   Ports:
//     kind_i      id_kind encoding (NPC_*)
//     cmp_i       branch condition from the ID comparator
//     pc_i        PC of the instruction in ID
//     imm16_i     branch offset field
//     jidx_i      jump index field
//     rs_data_i   forwarded rs value (register jump target)
//     taken_o     instruction transfers control
//     target_o    redirect address (mod 2^32)
//     link_addr_o pc_i + 8
module npc_target_calc
    import npc_redirect_unit_pkg::*;
(
    input  logic [2:0]  kind_i,
    input  logic        cmp_i,
    input  logic [31:0] pc_i,
    input  logic [15:0] imm16_i,
    input  logic [25:0] jidx_i,
    input  logic [31:0] rs_data_i,
    output logic        taken_o,
    output logic [31:0] target_o,
    output logic [31:0] link_addr_o
);

    logic [31:0] pc_plus4;

    assign pc_plus4    = pc_i + 32'd4;
    assign link_addr_o = pc_i + 32'd8;

    always_comb begin
        taken_o  = 1'b0;
        target_o = pc_plus4;
        case (kind_i)
            NPC_BR, NPC_BRL: begin
                taken_o  = cmp_i;
                target_o = pc_plus4 + npc_br_offset(imm16_i);
            end
            NPC_J: begin
                taken_o  = 1'b1;
                // Region comes from the delay-slot address, not id_pc.
                target_o = {pc_plus4[31:28], jidx_i, 2'b00};
            end
            NPC_JR: begin
                taken_o  = 1'b1;
                target_o = rs_data_i;
            end
            default: begin
                taken_o  = 1'b0;
                target_o = pc_plus4;
            end
        endcase
    end

endmodule

// File: rtl/npc_redirect_unit.sv
// npc_redirect_unit
//   IF-stage PC register and next-PC redirect. Consumes the ID-stage branch
//   decision and steers the fetch address, honouring one MIPS delay slot: the
//   target is loaded the clock after resolution, by which time the slot at
//   id_pc+4 is already in IF. A redirect resolved while fetch is held is
//   latched (PEND) and applied once the hold drops.
//   Optional feature macro: NPC_BRANCH_LIKELY_EN (squash delay slot of a
//   not-taken branch-likely via nullify_if_o). Undefined: nullify_if_o = 0.
//   Ports:
//     clk_i, reset_i          clock, synchronous active-high reset
//     if_hold_i               IF may not advance this cycle
//     id_stall_i              ID frozen, compare operands not final
//     id_valid_i              ID holds a real instruction
//     id_kind_i               NPC_* kind
//     id_cmp_i                branch condition
//     id_pc_i, id_imm16_i, id_jidx_i, id_rs_data_i   target operands
//     pc_if_o                 registered fetch address
//     link_addr_o             id_pc + 8
//     redirect_pending_o      latched target waiting for hold release
//     nullify_if_o            squash the slot entering IF/ID
//     adel_if_o               fetch address misaligned or out of window
module npc_redirect_unit
    import npc_redirect_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = NPC_RESET_PC,
    parameter logic [31:0] IMEM_LIMIT = NPC_IMEM_LIMIT
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        if_hold_i,
    input  logic        id_stall_i,
    input  logic        id_valid_i,
    input  logic [2:0]  id_kind_i,
    input  logic        id_cmp_i,
    input  logic [31:0] id_pc_i,
    input  logic [15:0] id_imm16_i,
    input  logic [25:0] id_jidx_i,
    input  logic [31:0] id_rs_data_i,
    output logic [31:0] pc_if_o,
    output logic [31:0] link_addr_o,
    output logic        redirect_pending_o,
    output logic        nullify_if_o,
    output logic        adel_if_o
);

    localparam logic ST_RUN  = 1'b0;
    localparam logic ST_PEND = 1'b1;

    logic        taken;
    logic [31:0] target;
    logic        resolve;

    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic        state_q, state_d;

    npc_target_calc u_target_calc (
        .kind_i      (id_kind_i),
        .cmp_i       (id_cmp_i),
        .pc_i        (id_pc_i),
        .imm16_i     (id_imm16_i),
        .jidx_i      (id_jidx_i),
        .rs_data_i   (id_rs_data_i),
        .taken_o     (taken),
        .target_o    (target),
        .link_addr_o (link_addr_o)
    );

    // Operands are only trusted once ID is no longer stalled.
    assign resolve = id_valid_i & ~id_stall_i & taken;

    always_comb begin
        pc_d          = pc_q;
        pend_target_d = pend_target_q;
        state_d       = state_q;
        if (if_hold_i) begin
            // PC frozen; a redirect resolving now is parked (last one wins).
            if (resolve) begin
                pend_target_d = target;
                state_d       = ST_PEND;
            end
        end else if (resolve) begin
            // A fresh resolution supersedes any parked target.
            pc_d    = target;
            state_d = ST_RUN;
        end else if (state_q == ST_PEND) begin
            pc_d    = pend_target_q;
            state_d = ST_RUN;
        end else begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_q          <= RESET_PC;
            pend_target_q <= 32'd0;
            state_q       <= ST_RUN;
        end else begin
            pc_q          <= pc_d;
            pend_target_q <= pend_target_d;
            state_q       <= state_d;
        end
    end

`ifdef NPC_BRANCH_LIKELY_EN
    logic nullify_q, nullify_d;
    logic brl_not_taken;

    assign brl_not_taken = id_valid_i & ~id_stall_i & ~id_cmp_i
                         & (id_kind_i == NPC_BRL);

    // Set wins over clear; otherwise held until a cycle where IF advances.
    always_comb begin
        nullify_d = nullify_q;
        if (brl_not_taken)
            nullify_d = 1'b1;
        else if (nullify_q && !if_hold_i)
            nullify_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i)
            nullify_q <= 1'b0;
        else
            nullify_q <= nullify_d;
    end

    assign nullify_if_o = nullify_q;
`else
    assign nullify_if_o = 1'b0;
`endif

    assign pc_if_o            = pc_q;
    assign redirect_pending_o = (state_q == ST_PEND);
    assign adel_if_o          = (pc_q[1:0] != 2'b00) | (pc_q < RESET_PC)
                              | (pc_q > IMEM_LIMIT);

endmodule

// File: tb/tb_npc_redirect_unit.sv
module tb_npc_redirect_unit;
    import npc_redirect_unit_pkg::*;

`ifdef NPC_BRANCH_LIKELY_EN
    localparam bit BRL_EN = 1'b1;
`else
    localparam bit BRL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        if_hold, id_stall, id_valid, id_cmp;
    logic [2:0]  id_kind;
    logic [31:0] id_pc, id_rs_data;
    logic [15:0] id_imm16;
    logic [25:0] id_jidx;
    logic [31:0] pc_if, link_addr;
    logic        pending, nullify, adel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    npc_redirect_unit dut (
        .clk_i              (clk),
        .reset_i            (reset),
        .if_hold_i          (if_hold),
        .id_stall_i         (id_stall),
        .id_valid_i         (id_valid),
        .id_kind_i          (id_kind),
        .id_cmp_i           (id_cmp),
        .id_pc_i            (id_pc),
        .id_imm16_i         (id_imm16),
        .id_jidx_i          (id_jidx),
        .id_rs_data_i       (id_rs_data),
        .pc_if_o            (pc_if),
        .link_addr_o        (link_addr),
        .redirect_pending_o (pending),
        .nullify_if_o       (nullify),
        .adel_if_o          (adel)
    );

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_id();
        id_valid = 1'b0; id_stall = 1'b0; id_kind = NPC_NONE; id_cmp = 1'b0;
    endtask

    task automatic do_jr(input logic [31:0] tgt);
        id_valid = 1'b1; id_kind = NPC_JR; id_rs_data = tgt; id_pc = 32'h0000_3100;
        tick();
        idle_id();
    endtask

    task automatic test_reset();
        reset = 1'b1; if_hold = 1'b0; idle_id();
        id_pc = 32'd0; id_imm16 = 16'd0; id_jidx = 26'd0; id_rs_data = 32'd0;
        tick(); tick();
        reset = 1'b0;
        checks++;
        if (pc_if !== 32'h3000 || pending !== 1'b0 || nullify !== 1'b0 || adel !== 1'b0) begin
            errors++;
            $display("FAIL reset: pc=%h pend=%b nul=%b adel=%b, expected 3000/0/0/0",
                     pc_if, pending, nullify, adel);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h3004; exp_pc[1] = 32'h3008; exp_pc[2] = 32'h300C;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (pc_if !== exp_pc[i] || adel !== 1'b0) begin
                errors++;
                $display("FAIL seq%0d: pc=%h adel=%b, expected %h/0", i, pc_if, adel, exp_pc[i]);
            end
        end
    endtask

    task automatic test_branch();
        id_valid = 1'b1; id_kind = NPC_BR; id_pc = 32'h3008; id_imm16 = 16'hFFFE; id_cmp = 1'b1;
        #1;
        checks++;
        if (link_addr !== 32'h3010) begin
            errors++;
            $display("FAIL br_link: got %h expected 00003010", link_addr);
        end
        tick();
        idle_id();
        checks++;
        if (pc_if !== 32'h3004) begin
            errors++;
            $display("FAIL br_target: got %h expected 00003004", pc_if);
        end
    endtask

    task automatic test_jump_hold();
        // pc_if currently 0x3004
        id_valid = 1'b1; id_kind = NPC_J; id_pc = 32'h3010; id_jidx = 26'h0000C10; if_hold = 1'b1;
        tick();
        idle_id();
        checks++;
        if (pc_if !== 32'h3004 || pending !== 1'b1) begin
            errors++;
            $display("FAIL j_hold1: pc=%h pend=%b, expected 00003004/1", pc_if, pending);
        end
        tick();
        checks++;
        if (pc_if !== 32'h3004 || pending !== 1'b1) begin
            errors++;
            $display("FAIL j_hold2: pc=%h pend=%b, expected 00003004/1", pc_if, pending);
        end
        if_hold = 1'b0;
        tick();
        checks++;
        if (pc_if !== 32'h3040 || pending !== 1'b0) begin
            errors++;
            $display("FAIL j_release: pc=%h pend=%b, expected 00003040/0", pc_if, pending);
        end
        tick();
        checks++;
        if (pc_if !== 32'h3044) begin
            errors++;
            $display("FAIL j_after: got %h expected 00003044", pc_if);
        end
    endtask

    task automatic test_last_wins();
        // Two resolutions under hold: the JR overwrites the J target.
        if_hold = 1'b1;
        id_valid = 1'b1; id_kind = NPC_J; id_pc = 32'h3010; id_jidx = 26'h0000C10;
        tick();
        id_kind = NPC_JR; id_rs_data = 32'h0000_3200;
        tick();
        idle_id();
        if_hold = 1'b0;
        tick();
        checks++;
        if (pc_if !== 32'h3200 || pending !== 1'b0) begin
            errors++;
            $display("FAIL last_wins: pc=%h pend=%b, expected 00003200/0", pc_if, pending);
        end
        // Parked target is overridden by a fresh resolve on the release cycle.
        if_hold = 1'b1;
        id_valid = 1'b1; id_kind = NPC_JR; id_rs_data = 32'h0000_3300;
        tick();
        if_hold = 1'b0; id_rs_data = 32'h0000_3400;
        tick();
        idle_id();
        checks++;
        if (pc_if !== 32'h3400 || pending !== 1'b0) begin
            errors++;
            $display("FAIL override: pc=%h pend=%b, expected 00003400/0", pc_if, pending);
        end
    endtask

    task automatic test_adel();
        do_jr(32'h0000_3002);
        checks++;
        if (pc_if !== 32'h3002 || adel !== 1'b1) begin
            errors++;
            $display("FAIL adel_misalign: pc=%h adel=%b, expected 00003002/1", pc_if, adel);
        end
        do_jr(32'h8000_0000);
        checks++;
        if (adel !== 1'b1) begin
            errors++;
            $display("FAIL adel_high: got %b expected 1", adel);
        end
        do_jr(32'h0000_6FFC);
        checks++;
        if (adel !== 1'b0) begin
            errors++;
            $display("FAIL adel_top_ok: got %b expected 0", adel);
        end
        tick();  // sequential step to 0x7000, one past the limit
        checks++;
        if (pc_if !== 32'h7000 || adel !== 1'b1) begin
            errors++;
            $display("FAIL adel_past_limit: pc=%h adel=%b, expected 00007000/1", pc_if, adel);
        end
        do_jr(32'h0000_2FFC);
        checks++;
        if (adel !== 1'b1) begin
            errors++;
            $display("FAIL adel_low: got %b expected 1", adel);
        end
        do_jr(32'hFFFF_FFFC);
        tick();
        checks++;
        if (pc_if !== 32'h0000_0000) begin
            errors++;
            $display("FAIL pc_wrap: got %h expected 00000000", pc_if);
        end
        do_jr(32'h0000_3000);
    endtask

    task automatic test_no_resolve();
        // pc_if = 0x3000
        id_valid = 1'b1; id_stall = 1'b1; id_kind = NPC_BR; id_cmp = 1'b1;
        id_pc = 32'h3008; id_imm16 = 16'h0010;
        tick();
        checks++;
        if (pc_if !== 32'h3004) begin
            errors++;
            $display("FAIL br_stalled: got %h expected 00003004", pc_if);
        end
        id_stall = 1'b0; id_valid = 1'b0;
        tick();
        checks++;
        if (pc_if !== 32'h3008) begin
            errors++;
            $display("FAIL br_invalid: got %h expected 00003008", pc_if);
        end
        id_valid = 1'b1; id_cmp = 1'b0;
        tick();
        idle_id();
        checks++;
        if (pc_if !== 32'h300C) begin
            errors++;
            $display("FAIL br_not_taken: got %h expected 0000300c", pc_if);
        end
    endtask

    task automatic test_brl();
        logic en;
        en = BRL_EN;
        // Not-taken BRL with IF free: one-clock squash, PC sequential.
        id_valid = 1'b1; id_kind = NPC_BRL; id_cmp = 1'b0; id_pc = 32'h3008; id_imm16 = 16'h0010;
        tick();
        idle_id();
        checks++;
        if (nullify !== en || pc_if !== 32'h3010) begin
            errors++;
            $display("FAIL brl_nt: nul=%b pc=%h, expected %b/00003010", nullify, pc_if, en);
        end
        tick();
        checks++;
        if (nullify !== 1'b0) begin
            errors++;
            $display("FAIL brl_clear: got %b expected 0", nullify);
        end
        // Under hold the flag persists until IF advances.
        id_valid = 1'b1; id_kind = NPC_BRL; id_cmp = 1'b0; if_hold = 1'b1;
        tick();
        idle_id();
        tick();
        checks++;
        if (nullify !== en || pc_if !== 32'h3014) begin
            errors++;
            $display("FAIL brl_hold: nul=%b pc=%h, expected %b/00003014", nullify, pc_if, en);
        end
        if_hold = 1'b0;
        tick();
        checks++;
        if (nullify !== 1'b0) begin
            errors++;
            $display("FAIL brl_hold_clear: got %b expected 0", nullify);
        end
        // Taken BRL redirects like BR: 0x3008+4+0x40 = 0x304C.
        id_valid = 1'b1; id_kind = NPC_BRL; id_cmp = 1'b1; id_pc = 32'h3008;
        tick();
        idle_id();
        checks++;
        if (pc_if !== 32'h304C || nullify !== 1'b0) begin
            errors++;
            $display("FAIL brl_taken: pc=%h nul=%b, expected 0000304c/0", pc_if, nullify);
        end
    endtask

    task automatic test_reset_mid_pend();
        if_hold = 1'b1;
        id_valid = 1'b1; id_kind = NPC_JR; id_rs_data = 32'h0000_5000;
        tick();
        idle_id();
        checks++;
        if (pending !== 1'b1) begin
            errors++;
            $display("FAIL pend_set: got %b expected 1", pending);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0; if_hold = 1'b0;
        checks++;
        if (pc_if !== 32'h3000 || pending !== 1'b0) begin
            errors++;
            $display("FAIL pend_reset: pc=%h pend=%b, expected 00003000/0", pc_if, pending);
        end
        tick();
        checks++;
        if (pc_if !== 32'h3004) begin
            errors++;
            $display("FAIL pend_discard: got %h expected 00003004", pc_if);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jump_hold();
        test_last_wins();
        test_adel();
        test_no_resolve();
        test_brl();
        test_reset_mid_pend();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
